// File: rtl/connect4_pkg.sv
// Shared constants, drop-strobe encodings and FSM state type for the
// Connect-4 turn controller that drives ColumnsCircuit.
package connect4_pkg;

  localparam logic [1:0] ST_HOLD = 2'b00;
  localparam logic [1:0] ST_P1   = 2'b01;
  localparam logic [1:0] ST_P2   = 2'b10;

  localparam int unsigned BOARD_CELLS = 16;
  localparam int unsigned N_COLUMNS   = 4;

  typedef enum logic [2:0] {
    S_SELECT,
    S_ARMED,
    S_COMMIT,
    S_CHECK,
    S_OVER
  } fsm_state_e;

  // True when exactly one bit of the column vector is set.
  function automatic logic is_one_hot(input logic [N_COLUMNS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debounce counter and rising-edge
// detector for one raw push button; press is a single-cycle event.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/connect4_turn_controller.sv
// Turn controller: debounced buttons select a column, a confirm press issues
// a one-cycle drop strobe, and the ColumnsCircuit verdict advances the game.
module connect4_turn_controller
  import connect4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_COLUMNS-1:0]   btn_column,
  input  logic                   btn_drop,
  input  logic                   btn_new_game,
  input  logic                   invalid_column,
  input  logic [BOARD_CELLS-1:0] in_gameboard,
  output logic [N_COLUMNS-1:0]   out_column,
  output logic [1:0]             state,
  output logic                   current_player,
  output logic [4:0]             move_count,
  output logic                   reject_pulse,
  output logic                   game_over
);

  localparam logic [4:0] MC_MAX = 5'(BOARD_CELLS);

  logic [N_COLUMNS-1:0] col_press;
  logic                 drop_press;
  logic                 new_game_press;
  logic                 col_ok;

  for (genvar i = 0; i < N_COLUMNS; i++) begin : g_col_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_col_db (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_column[i]),
      .press  (col_press[i])
    );
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_drop_db (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_drop),
    .press  (drop_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_new_game_db (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_new_game),
    .press  (new_game_press)
  );

  fsm_state_e           fsm_q, fsm_d;
  logic [N_COLUMNS-1:0] out_column_q, out_column_d;
  logic                 player_q, player_d;
  logic [4:0]           move_count_q, move_count_d;
  logic                 reject;

  assign col_ok = is_one_hot(col_press);

  always_comb begin
    fsm_d        = fsm_q;
    out_column_d = out_column_q;
    player_d     = player_q;
    move_count_d = move_count_q;
    reject       = 1'b0;

    unique case (fsm_q)
      S_SELECT: begin
        if (col_ok) begin
          out_column_d = col_press;
          fsm_d        = S_ARMED;
        end
      end
      S_ARMED: begin
        if (drop_press) begin
          fsm_d = S_COMMIT;
        end else if (col_ok) begin
          out_column_d = col_press;
        end
      end
      S_COMMIT: begin
        fsm_d = S_CHECK;
      end
      S_CHECK: begin
        out_column_d = '0;
        if (invalid_column) begin
          reject = 1'b1;
          fsm_d  = S_SELECT;
        end else begin
          move_count_d = (move_count_q >= MC_MAX) ? MC_MAX : move_count_q + 1'b1;
          player_d     = ~player_q;
          fsm_d        = ((&in_gameboard) || (move_count_d == MC_MAX)) ? S_OVER : S_SELECT;
        end
      end
      S_OVER: begin
        fsm_d = S_OVER;
      end
      default: begin
        fsm_d = S_SELECT;
      end
    endcase

    // Restart wins over anything else decided this cycle.
    if (new_game_press) begin
      fsm_d        = S_SELECT;
      out_column_d = '0;
      player_d     = 1'b0;
      move_count_d = '0;
      reject       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= S_SELECT;
      out_column_q <= '0;
      player_q     <= 1'b0;
      move_count_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      out_column_q <= out_column_d;
      player_q     <= player_d;
      move_count_q <= move_count_d;
    end
  end

  assign state          = (fsm_q == S_COMMIT) ? (player_q ? ST_P2 : ST_P1) : ST_HOLD;
  assign out_column     = out_column_q;
  assign current_player = player_q;
  assign move_count     = move_count_q;
  assign reject_pulse   = reject;
  assign game_over      = (fsm_q == S_OVER);

endmodule
